alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_if.sv | 18 +
 rtl/alu_seq.sv | 99 +++++++++
 2 files changed

// File: rtl/alu_if.sv
// alu_if: request/response handshake bundle between an ALU client and alu_seq
interface alu_if #(parameter int LENGTH = 32);
    logic              in_valid;
    logic              in_ready;
    logic [LENGTH-1:0] A;
    logic [LENGTH-1:0] B;
    logic [3:0]        control;
    logic              out_valid;
    logic              out_ready;
    logic [LENGTH-1:0] Result;
    logic              zeroflag;
    logic              negativeflag;
    logic              divzero;
    modport master (output in_valid, A, B, control, out_ready,
                    input in_ready, out_valid, Result, zeroflag, negativeflag, divzero);
    modport slave (input in_valid, A, B, control, out_ready,
                   output in_ready, out_valid, Result, zeroflag, negativeflag, divzero);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops plus iterative shift-add multiply and restoring divide
module alu_seq #(parameter int LENGTH = 32) (
    input logic clk,
    input logic reset,
    alu_if.slave bus
);
    localparam int SHW = $clog2(LENGTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_n;
    logic [LENGTH-1:0] a_r, b_r, acc, q, alu, ld_val, mul_acc, rem_n, quo_n, res;
    logic [LENGTH:0] div_sh;
    logic [3:0] op_r, c;
    logic [SHW-1:0] cnt, sh;
    logic accept, last, div_ge, ld, ld_dz, is_mul, is_div, zf, nf, dz;
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        if (state == IDLE && accept)
            state_n = is_mul ? MUL : is_div ? DIV : DONE;
        else if ((state == MUL || state == DIV) && last)
            state_n = DONE;
        else if (state == DONE && bus.out_ready)
            state_n = IDLE;
    end
    always_comb begin
        bus.in_ready     = state == IDLE;
        bus.out_valid    = state == DONE;
        bus.Result       = res;
        bus.zeroflag     = zf;
        bus.negativeflag = nf;
        bus.divzero      = dz;
    end
    always_comb begin
        c       = bus.control;
        sh      = bus.B[SHW-1:0];
        is_mul  = c == 4'b1100;
        is_div  = c == 4'b1001 || c == 4'b1010;
        accept  = state == IDLE && bus.in_valid;
        last    = cnt == SHW'(LENGTH - 1);
        alu     = c == 4'b0000 ? bus.A + bus.B :
                  c == 4'b1000 ? bus.A - bus.B :
                  c == 4'b0111 ? bus.A & bus.B :
                  c == 4'b0110 ? bus.A | bus.B :
                  c == 4'b0100 ? bus.A ^ bus.B :
                  c == 4'b0001 ? bus.A << sh :
                  c == 4'b0101 ? bus.A >> sh :
                  c == 4'b1101 ? $unsigned($signed(bus.A) >>> sh) :
                  c == 4'b0010 ? LENGTH'($signed(bus.A) < $signed(bus.B)) :
                  c == 4'b0011 ? LENGTH'(bus.A < bus.B) : '0;
        mul_acc = acc + (q[0] ? a_r : '0);
        // q holds the dividend being shifted out MSB-first while quotient bits shift in at the bottom
        div_sh  = {acc, q[LENGTH-1]};
        div_ge  = div_sh >= {1'b0, b_r};
        rem_n   = div_ge ? div_sh[LENGTH-1:0] - b_r : div_sh[LENGTH-1:0];
        quo_n   = {q[LENGTH-2:0], div_ge};
        ld      = (accept && !is_mul && !is_div) || ((state == MUL || state == DIV) && last);
        ld_val  = state == MUL ? mul_acc : state == DIV ? (op_r == 4'b1001 ? quo_n : rem_n) : alu;
        ld_dz   = state == DIV && b_r == '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            res  <= '0;
            zf   <= 1'b1;
            nf   <= 1'b0;
            dz   <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            q    <= '0;
            a_r  <= '0;
            b_r  <= '0;
            op_r <= '0;
        end else begin
            if (accept) begin
                a_r  <= bus.A;
                b_r  <= bus.B;
                op_r <= c;
                acc  <= '0;
                q    <= is_mul ? bus.B : bus.A;
                cnt  <= '0;
            end else if (state == MUL) begin
                acc <= mul_acc;
                a_r <= a_r << 1;
                q   <= q >> 1;
                cnt <= cnt + SHW'(1);
            end else if (state == DIV) begin
                acc <= rem_n;
                q   <= quo_n;
                cnt <= cnt + SHW'(1);
            end
            if (ld) begin
                res <= ld_val;
                zf  <= ld_val == '0;
                nf  <= ld_val[LENGTH-1];
                dz  <= ld_dz;
            end
        end
    end
endmodule
